expr_fold_eval: RTL and testbench



---
 rtl/expr_fold_eval_if.sv | 20 ++
 rtl/expr_fold_eval.sv | 95 +++++++++
 tb/tb_expr_fold_eval.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/expr_fold_eval_if.sv
// expr_fold_eval_if: operand/result handshake bundle for the folded expression evaluator
interface expr_fold_eval_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X, Y, Z, P, Q, R, S, T;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] output1, output2, output3, output4, output5, output6;
    logic             busy;

    modport master (
        output in_valid, X, Y, Z, P, Q, R, S, T, out_ready,
        input  in_ready, out_valid, output1, output2, output3, output4, output5, output6, busy
    );

    modport slave (
        input  in_valid, X, Y, Z, P, Q, R, S, T, out_ready,
        output in_ready, out_valid, output1, output2, output3, output4, output5, output6, busy
    );
endinterface

// File: rtl/expr_fold_eval.sv
// expr_fold_eval: 12-step evaluator sharing one multiplier and one adder/subtractor
module expr_fold_eval #(parameter int WIDTH = 32) (
    input logic             clk,
    input logic             rst_n,
    expr_fold_eval_if.slave bus
);
    typedef enum logic [3:0] {IDLE, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x, y, z, p, q, r, s, t;
    logic [WIDTH-1:0] zp, xy, qr, xs, ys, xq, px, xyp3, xp, pxr;
    logic [WIDTH-1:0] mul_a, mul_b, add_a, add_b, mul_y, add_y;
    logic             sub;

    // steer the current step's operands onto the shared multiplier and adder/subtractor
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        add_a = '0;
        add_b = '0;
        sub   = 1'b0;
        case (state)
            S1:  begin add_a = z;  add_b = p;  mul_a = x;  mul_b = y;  end
            S2:  begin add_a = q;  add_b = r;  sub = 1'b1; end
            S3:  begin add_a = x;  add_b = y;  mul_a = zp; mul_b = qr; end
            S4:  begin add_a = xy; add_b = zp; end
            S5:  begin add_a = xs; add_b = s;  end
            S6:  begin add_a = ys; add_b = t;  end
            S7:  begin add_a = xy; add_b = q;  end
            S8:  begin add_a = p;  add_b = x;  end
            S9:  begin add_a = xs; add_b = p;  mul_a = xq; mul_b = px; end
            S10: begin add_a = xy; add_b = p;  mul_a = xyp3; mul_b = qr; end
            S11: begin add_a = px; add_b = r;  end
            S12: begin add_a = xp; add_b = pxr; sub = 1'b1; end
            default: ;
        endcase
    end

    assign mul_y = mul_a * mul_b;
    assign add_y = sub ? add_a - add_b : add_a + add_b;

    // sequencer: accept, step through the schedule registering each result, then hold until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.output1   <= '0;
            bus.output2   <= '0;
            bus.output3   <= '0;
            bus.output4   <= '0;
            bus.output5   <= '0;
            bus.output6   <= '0;
            {x, y, z, p, q, r, s, t} <= '0;
            {zp, xy, qr, xs, ys, xq, px, xyp3, xp, pxr} <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    {x, y, z, p, q, r, s, t} <= {bus.X, bus.Y, bus.Z, bus.P, bus.Q, bus.R, bus.S, bus.T};
                    state        <= S1;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b1;
                end
                DONE: if (bus.out_ready) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
                default: begin
                    state <= state_t'(state + 4'd1);
                    case (state)
                        S1:  begin zp <= add_y; xy <= mul_y; end
                        S2:  qr <= add_y;
                        S3:  begin xs <= add_y; bus.output2 <= mul_y; end
                        S4:  bus.output1 <= add_y;
                        S5:  ys <= add_y;
                        S6:  bus.output3 <= add_y;
                        S7:  xq <= add_y;
                        S8:  px <= add_y;
                        S9:  begin xyp3 <= add_y; bus.output4 <= mul_y; end
                        S10: begin xp <= add_y; bus.output6 <= mul_y; end
                        S11: pxr <= add_y;
                        S12: begin
                            bus.output5   <= add_y;
                            bus.busy      <= 1'b0;
                            bus.out_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_expr_fold_eval.sv
// tb_expr_fold_eval: randomized and directed checks of the folded evaluator against an arithmetic model
module tb_expr_fold_eval;
    typedef logic [7:0][31:0] vec_t;
    typedef logic [5:0][31:0] res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    expr_fold_eval_if #(.WIDTH(32)) bus();
    expr_fold_eval #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // free-running cycle count used to measure initiation interval
    always @(posedge clk) cyc++;

    function automatic res_t model(input vec_t v);
        logic [31:0] x, y, z, p, q, r, s, t;
        res_t o;
        {t, s, r, q, p, z, y, x} = v;
        o[0] = x * y + (z + p);
        o[1] = (p + z) * (q - r);
        o[2] = y + s + x + t;
        o[3] = (x * y + q) * (p + x);
        o[4] = (x * y + p) - (r + p + x);
        o[5] = (x + y + p) * (q - r);
        return o;
    endfunction

    function automatic res_t observed();
        return {bus.output6, bus.output5, bus.output4, bus.output3, bus.output2, bus.output1};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        {bus.T, bus.S, bus.R, bus.Q, bus.P, bus.Z, bus.Y, bus.X} = v;
    endtask

    task automatic check_res(input string tag, input res_t exp);
        res_t got = observed();
        for (int j = 0; j < 6; j++) check($sformatf("%s_o%0d", tag, j + 1), got[j], exp[j]);
    endtask

    task automatic transact(input string name, input vec_t v, input int stall,
                            input bit hold_valid, input bit corrupt, output int acc_cyc);
        res_t exp = model(v);
        res_t held;
        int   n = 0;
        drive(v);
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        while (!bus.in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_accept"}, bus.in_ready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (!hold_valid) bus.in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (corrupt && i == 1) drive('1);
            check($sformatf("%s_busy_s%0d", name, i + 1), {bus.busy, bus.out_valid, bus.in_ready}, 3'b100);
            @(posedge clk); #1;
        end
        check({name, "_done"}, {bus.busy, bus.out_valid, bus.in_ready}, 3'b010);
        check_res(name, exp);
        held = observed();
        for (int k = 0; k < stall; k++) begin
            bus.in_valid = 1'b1;
            drive({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            @(posedge clk); #1;
            check($sformatf("%s_stall%0d", name, k), {bus.busy, bus.out_valid, bus.in_ready}, 3'b010);
            check_res($sformatf("%s_hold%0d", name, k), held);
        end
        if (stall > 0) begin
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({name, "_idle"}, {bus.busy, bus.out_valid, bus.in_ready}, 3'b001);
        check_res({name, "_kept"}, held);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t v1, v2, vr;
        int   a1, a2;
        v1 = {32'd6, 32'd1, 32'd7, 32'd10, 32'd5, 32'd4, 32'd3, 32'd2};
        v2 = '0;
        v2[0] = 32'h0001_0000;
        v2[1] = 32'h0001_0000;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive('0);
        #12;
        check("rst_ctrl", {bus.busy, bus.out_valid, bus.in_ready}, 3'b001);
        check_res("rst", '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        transact("t1", v1, 0, 1'b0, 1'b0, a1);
        transact("t2", v2, 0, 1'b0, 1'b0, a1);
        transact("t3", v1, 5, 1'b0, 1'b0, a1);

        drive(v1);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        check("t4_rst_ctrl", {bus.busy, bus.out_valid, bus.in_ready}, 3'b001);
        check_res("t4_rst", '0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        transact("t4_next", v2, 0, 1'b0, 1'b0, a1);

        transact("t5a", v1, 0, 1'b1, 1'b0, a1);
        transact("t5b", v2, 0, 1'b1, 1'b0, a2);
        bus.in_valid = 1'b0;
        check("t5_ii", a2 - a1, 14);

        transact("t6", v1, 0, 1'b0, 1'b1, a1);

        for (int n = 0; n < 20; n++) begin
            vr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            transact($sformatf("rnd%0d", n), vr, $urandom_range(0, 3), 1'b0, 1'b0, a1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
